// File: rtl/mem_issue_queue_if.sv
// mem_issue_queue_if: dispatch, wakeup, issue and status signals of the memory issue queue.
//
// Signal groups:
//   dispatch : i_wr_en, i_uop, i_func, i_rd, i_rs1, i_rs2, i_imm, i_rdy1, i_rdy2
//   wakeup   : i_wk_val0/i_wk_tag0, i_wk_val1/i_wk_tag1
//   control  : i_stall, i_flush
//   issue    : o_valid, o_uop, o_func, o_rd, o_rs1, o_rs2, o_imm
//   status   : o_full, o_empty, o_count
// Modports: master drives the i_* side (dispatch/writeback/downstream), slave is the queue.
interface mem_issue_queue_if #(
    parameter int unsigned DEPTH_LOG = 3,
    parameter int unsigned WIDTH_REG = 7
);
    logic                 i_wr_en;
    logic [6:0]           i_uop;
    logic [9:0]           i_func;
    logic [WIDTH_REG-1:0] i_rd;
    logic [WIDTH_REG-1:0] i_rs1;
    logic [WIDTH_REG-1:0] i_rs2;
    logic [31:0]          i_imm;
    logic                 i_rdy1;
    logic                 i_rdy2;
    logic                 i_wk_val0;
    logic [WIDTH_REG-1:0] i_wk_tag0;
    logic                 i_wk_val1;
    logic [WIDTH_REG-1:0] i_wk_tag1;
    logic                 i_stall;
    logic                 i_flush;

    logic                 o_valid;
    logic [6:0]           o_uop;
    logic [9:0]           o_func;
    logic [WIDTH_REG-1:0] o_rd;
    logic [WIDTH_REG-1:0] o_rs1;
    logic [WIDTH_REG-1:0] o_rs2;
    logic [31:0]          o_imm;
    logic                 o_full;
    logic                 o_empty;
    logic [DEPTH_LOG:0]   o_count;

    modport master (
        output i_wr_en, i_uop, i_func, i_rd, i_rs1, i_rs2, i_imm, i_rdy1, i_rdy2,
        output i_wk_val0, i_wk_tag0, i_wk_val1, i_wk_tag1, i_stall, i_flush,
        input  o_valid, o_uop, o_func, o_rd, o_rs1, o_rs2, o_imm, o_full, o_empty, o_count
    );

    modport slave (
        input  i_wr_en, i_uop, i_func, i_rd, i_rs1, i_rs2, i_imm, i_rdy1, i_rdy2,
        input  i_wk_val0, i_wk_tag0, i_wk_val1, i_wk_tag1, i_stall, i_flush,
        output o_valid, o_uop, o_func, o_rd, o_rs1, o_rs2, o_imm, o_full, o_empty, o_count
    );
endinterface

// File: rtl/mem_issue_queue.sv
// mem_issue_queue: in-order issue queue for load/store uops feeding the memory execution unit.
//
// Holds dispatched uops in a circular buffer, tracks source readiness from two writeback
// wakeup ports and issues only the oldest entry, once both its sources are ready, into a
// registered output stage. A non-ready head blocks all younger entries.
//
// Ports:
//   i_clk   : clock
//   i_rst_n : asynchronous active-low reset
//   q       : mem_issue_queue_if.slave (dispatch, wakeup, stall/flush, issue, status)
//
// Optional build macro MEMQ_WAKEUP_BYPASS_EN: head readiness also sees the current-cycle
// wakeup matches, cutting wakeup-to-issue latency from 2 cycles to 1.
module mem_issue_queue #(
    parameter int unsigned DEPTH_LOG = 3,
    parameter int unsigned WIDTH_REG = 7
) (
    input logic             i_clk,
    input logic             i_rst_n,
    mem_issue_queue_if.slave q
);
    localparam int unsigned DEPTH    = 1 << DEPTH_LOG;
    localparam logic [6:0]  UOP_LOAD = 7'b0000011;

    typedef logic [DEPTH_LOG-1:0] ptr_t;
    typedef logic [WIDTH_REG-1:0] tag_t;

    // Entry state
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] rdy1_q;
    logic [DEPTH-1:0] rdy2_q;
    logic [6:0]       uop_q  [DEPTH];
    logic [9:0]       func_q [DEPTH];
    tag_t             rd_q   [DEPTH];
    tag_t             rs1_q  [DEPTH];
    tag_t             rs2_q  [DEPTH];
    logic [31:0]      imm_q  [DEPTH];

    ptr_t             head_q;
    ptr_t             tail_q;
    logic [DEPTH_LOG:0] count_q;

    // Issue register
    logic             o_valid_q;
    logic [6:0]       o_uop_q;
    logic [9:0]       o_func_q;
    tag_t             o_rd_q;
    tag_t             o_rs1_q;
    tag_t             o_rs2_q;
    logic [31:0]      o_imm_q;

    function automatic logic wake_hit(input tag_t tag, input logic v0, input tag_t t0,
                                      input logic v1, input tag_t t1);
        return (v0 && (t0 == tag)) || (v1 && (t1 == tag));
    endfunction

    logic full;
    logic push;
    logic pop;
    logic head_rdy1;
    logic head_rdy2;
    logic head_ready;
    logic disp_rdy1;
    logic disp_rdy2;

    assign full = (count_q == (DEPTH_LOG+1)'(DEPTH));

    always_comb begin
        head_rdy1 = rdy1_q[head_q];
        head_rdy2 = rdy2_q[head_q];
`ifdef MEMQ_WAKEUP_BYPASS_EN
        head_rdy1 = head_rdy1 | wake_hit(rs1_q[head_q], q.i_wk_val0, q.i_wk_tag0,
                                         q.i_wk_val1, q.i_wk_tag1);
        head_rdy2 = head_rdy2 | wake_hit(rs2_q[head_q], q.i_wk_val0, q.i_wk_tag0,
                                         q.i_wk_val1, q.i_wk_tag1);
`endif
        head_ready = valid_q[head_q] && head_rdy1 && head_rdy2;
    end

    // A full queue drops the dispatch even if the head pops this cycle.
    assign push = q.i_wr_en && !full;
    assign pop  = head_ready && (!o_valid_q || !q.i_stall);

    // x0 is always ready; loads never read rs2.
    assign disp_rdy1 = q.i_rdy1 || (q.i_rs1 == '0) ||
                       wake_hit(q.i_rs1, q.i_wk_val0, q.i_wk_tag0, q.i_wk_val1, q.i_wk_tag1);
    assign disp_rdy2 = (q.i_uop == UOP_LOAD) || q.i_rdy2 || (q.i_rs2 == '0) ||
                       wake_hit(q.i_rs2, q.i_wk_val0, q.i_wk_tag0, q.i_wk_val1, q.i_wk_tag1);

    // Payload storage needs no reset; valid_q qualifies it.
    always_ff @(posedge i_clk) begin
        if (push && !q.i_flush) begin
            uop_q[tail_q]  <= q.i_uop;
            func_q[tail_q] <= q.i_func;
            rd_q[tail_q]   <= q.i_rd;
            rs1_q[tail_q]  <= q.i_rs1;
            rs2_q[tail_q]  <= q.i_rs2;
            imm_q[tail_q]  <= q.i_imm;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q   <= '0;
            rdy1_q    <= '0;
            rdy2_q    <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            o_valid_q <= 1'b0;
            o_uop_q   <= '0;
            o_func_q  <= '0;
            o_rd_q    <= '0;
            o_rs1_q   <= '0;
            o_rs2_q   <= '0;
            o_imm_q   <= '0;
        end else if (q.i_flush) begin
            valid_q   <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            o_valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (valid_q[i]) begin
                    if (wake_hit(rs1_q[i], q.i_wk_val0, q.i_wk_tag0, q.i_wk_val1, q.i_wk_tag1))
                        rdy1_q[i] <= 1'b1;
                    if (wake_hit(rs2_q[i], q.i_wk_val0, q.i_wk_tag0, q.i_wk_val1, q.i_wk_tag1))
                        rdy2_q[i] <= 1'b1;
                end
            end

            // Head and tail coincide only when empty (no pop) or full (no push).
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + ptr_t'(1);
            end
            if (push) begin
                valid_q[tail_q] <= 1'b1;
                rdy1_q[tail_q]  <= disp_rdy1;
                rdy2_q[tail_q]  <= disp_rdy2;
                tail_q          <= tail_q + ptr_t'(1);
            end

            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase

            if (pop) begin
                o_valid_q <= 1'b1;
                o_uop_q   <= uop_q[head_q];
                o_func_q  <= func_q[head_q];
                o_rd_q    <= rd_q[head_q];
                o_rs1_q   <= rs1_q[head_q];
                o_rs2_q   <= rs2_q[head_q];
                o_imm_q   <= imm_q[head_q];
            end else if (!(o_valid_q && q.i_stall)) begin
                o_valid_q <= 1'b0;
            end
        end
    end

    assign q.o_valid = o_valid_q;
    assign q.o_uop   = o_uop_q;
    assign q.o_func  = o_func_q;
    assign q.o_rd    = o_rd_q;
    assign q.o_rs1   = o_rs1_q;
    assign q.o_rs2   = o_rs2_q;
    assign q.o_imm   = o_imm_q;
    assign q.o_full  = full;
    assign q.o_empty = (count_q == '0);
    assign q.o_count = count_q;
endmodule
